// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared operand-select encodings and the scoreboard entry type
//               used by the hazard/forwarding controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int SB_RA_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_ALT = 2'b11;

    typedef struct packed {
        logic               v;
        logic [SB_RA_W-1:0] rd;
        logic               wr;
        logic               ld;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module      : hazard_match
// Description : Compares one source operand against one scoreboard slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import cpu_pkg::*;
(
    input  sb_entry_t          entry,
    input  logic [SB_RA_W-1:0] src,
    input  logic               uses,
    output logic               hit
);

    // A slot that neither writes nor loads can never satisfy a dependency.
    assign hit = uses & entry.v & (entry.wr | entry.ld) & (entry.rd == src);

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Decode-side hazard detection, operand forwarding select and
//               regfile write-port-1 control with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
    import cpu_pkg::*;
#(
    parameter int RA_W   = SB_RA_W,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [RA_W-1:0]  dec_rn,
    input  logic             dec_uses_rn,
    input  logic [RA_W-1:0]  dec_rm,
    input  logic             dec_uses_rm,
    input  logic [RA_W-1:0]  dec_rs,
    input  logic             dec_uses_rs,
    input  logic [RA_W-1:0]  dec_rd,
    input  logic             dec_wr_rd,
    input  logic             dec_is_load,
    input  logic             flush,
    output logic [1:0]       sel_A_in,
    output logic [1:0]       sel_B_in,
    output logic [1:0]       sel_shift_in,
    output logic             stall,
    output logic [RA_W-1:0]  w_addr1,
    output logic             w_en1,
    output logic             sel_w_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [RA_W-1:0]  src [3];
    logic [2:0]       live;
    logic [2:0]       ex_hit;
    logic [2:0]       mem_hit;
    logic [2:0]       fwd;
    logic             load_use;
    logic             port_conflict;

    // The PC register reads as the PC itself, so it never creates a dependency.
    always_comb begin
        src[0] = dec_rn;
        src[1] = dec_rm;
        src[2] = dec_rs;
        live   = {dec_uses_rs & (dec_rs != PC_ADDR),
                  dec_uses_rm & (dec_rm != PC_ADDR),
                  dec_uses_rn & (dec_rn != PC_ADDR)};
    end

    for (genvar i = 0; i < 3; i++) begin : g_ops
        hazard_match u_ex_match (
            .entry (ex_q),
            .src   (src[i]),
            .uses  (live[i]),
            .hit   (ex_hit[i])
        );
        hazard_match u_mem_match (
            .entry (mem_q),
            .src   (src[i]),
            .uses  (live[i]),
            .hit   (mem_hit[i])
        );
    end

    always_comb begin
        fwd           = ex_hit & {3{ex_q.wr & ~ex_q.ld}};
        load_use      = (|(ex_hit & {3{ex_q.ld}})) | (|mem_hit);
        // A load in EX owns port 1 next cycle; an ALU writer behind it must wait.
        port_conflict = ex_q.v & ex_q.ld & dec_wr_rd & ~dec_is_load;
        stall         = dec_valid & ~flush & (load_use | port_conflict);
    end

    always_comb begin
        sel_A_in = FWD_REG;
        if (dec_uses_rn) begin
            if (dec_rn == PC_ADDR) begin
                sel_A_in = FWD_ALT;
            end else if (fwd[0]) begin
                sel_A_in = FWD_ALU;
            end
        end
        sel_B_in     = fwd[1] ? FWD_ALU : FWD_REG;
        sel_shift_in = !dec_uses_rs ? FWD_ALT : (fwd[2] ? FWD_ALU : FWD_REG);
    end

    always_comb begin
        w_en1      = 1'b0;
        w_addr1    = '0;
        sel_w_data = 1'b0;
        if (mem_q.v) begin
            w_en1      = 1'b1;
            w_addr1    = mem_q.rd;
            sel_w_data = 1'b1;
        end else if (ex_q.v & ex_q.wr & ~ex_q.ld) begin
            w_en1   = 1'b1;
            w_addr1 = ex_q.rd;
        end
    end

    always_comb begin
        ex_d = '0;
        if (dec_valid & ~stall & ~flush) begin
            ex_d.v  = 1'b1;
            ex_d.rd = dec_rd;
            ex_d.wr = dec_wr_rd;
            ex_d.ld = dec_is_load;
        end
        mem_d = '0;
        if (ex_q.v & ex_q.ld & ex_q.wr) begin
            mem_d = ex_q;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed and randomized checks of hazard_unit against an
//               instruction-level model of the EX/MEM pipeline occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PC      = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid;
    logic [3:0]       dec_rn, dec_rm, dec_rs, dec_rd;
    logic             dec_uses_rn, dec_uses_rm, dec_uses_rs;
    logic             dec_wr_rd, dec_is_load, flush;
    logic [1:0]       sel_A_in, sel_B_in, sel_shift_in;
    logic             stall;
    logic [3:0]       w_addr1;
    logic             w_en1;
    logic             sel_w_data;
    logic [CNT_W-1:0] stall_cnt;

    hazard_unit #(.RA_W(4), .PC_REG(PC), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_rn       (dec_rn),
        .dec_uses_rn  (dec_uses_rn),
        .dec_rm       (dec_rm),
        .dec_uses_rm  (dec_uses_rm),
        .dec_rs       (dec_rs),
        .dec_uses_rs  (dec_uses_rs),
        .dec_rd       (dec_rd),
        .dec_wr_rd    (dec_wr_rd),
        .dec_is_load  (dec_is_load),
        .flush        (flush),
        .sel_A_in     (sel_A_in),
        .sel_B_in     (sel_B_in),
        .sel_shift_in (sel_shift_in),
        .stall        (stall),
        .w_addr1      (w_addr1),
        .w_en1        (w_en1),
        .sel_w_data   (sel_w_data),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Issued instructions, stamped with the cycle in which they sit in EX.
    typedef struct {
        int rd;
        bit wr;
        bit ld;
        int enter;
    } rec_t;

    rec_t q[$];
    int   cyc;
    int   exp_cnt;
    int   stalls_seen;
    int   vectors;
    int   miscompares;

    int   e_selA, e_selB, e_shift, e_addr, e_cnt;
    bit   e_stall, e_wen, e_wsel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_expect();
        bit   exv;
        bit   memv;
        bit   lu;
        bit   sh;
        bit   fw [3];
        rec_t exr;
        rec_t memr;
        int   srcs [3];
        bit   us [3];
        exv = 0; memv = 0; lu = 0;
        exr = '{0, 0, 0, 0};
        memr = '{0, 0, 0, 0};
        srcs = '{int'(dec_rn), int'(dec_rm), int'(dec_rs)};
        us   = '{dec_uses_rn, dec_uses_rm, dec_uses_rs};
        foreach (q[i]) begin
            if (q[i].enter == cyc) begin
                exv = 1; exr = q[i];
            end
            if (q[i].enter == cyc - 1 && q[i].ld && q[i].wr) begin
                memv = 1; memr = q[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            bit live;
            live  = us[i] && srcs[i] != PC;
            fw[i] = live && exv && exr.wr && !exr.ld && exr.rd == srcs[i];
            if (live && ((exv && exr.ld && exr.rd == srcs[i]) || (memv && memr.rd == srcs[i])))
                lu = 1;
        end
        sh      = exv && exr.ld && dec_wr_rd && !dec_is_load;
        e_stall = dec_valid && !flush && (lu || sh);
        e_selA  = !dec_uses_rn ? 0 : (dec_rn == PC) ? 3 : fw[0] ? 1 : 0;
        e_selB  = fw[1] ? 1 : 0;
        e_shift = !dec_uses_rs ? 3 : fw[2] ? 1 : 0;
        if (memv) begin
            e_wen = 1; e_addr = memr.rd; e_wsel = 1;
        end else if (exv && exr.wr && !exr.ld) begin
            e_wen = 1; e_addr = exr.rd; e_wsel = 0;
        end else begin
            e_wen = 0; e_addr = 0; e_wsel = 0;
        end
        e_cnt = exp_cnt;
    endtask

    task automatic check_model(input string tag);
        model_expect();
        chk({tag, ".selA"},  32'(sel_A_in),     32'(e_selA));
        chk({tag, ".selB"},  32'(sel_B_in),     32'(e_selB));
        chk({tag, ".shift"}, 32'(sel_shift_in), 32'(e_shift));
        chk({tag, ".stall"}, 32'(stall),        32'(e_stall));
        chk({tag, ".wen"},   32'(w_en1),        32'(e_wen));
        chk({tag, ".waddr"}, 32'(w_addr1),      32'(e_addr));
        chk({tag, ".wsel"},  32'(sel_w_data),   32'(e_wsel));
        chk({tag, ".cnt"},   32'(stall_cnt),    32'(e_cnt));
    endtask

    task automatic drive(input int v, input int rn, input int un, input int rm, input int um,
                         input int rs, input int us, input int rd, input int wr, input int ld,
                         input int fl);
        dec_valid   = 1'(v);
        dec_rn      = 4'(rn); dec_uses_rn = 1'(un);
        dec_rm      = 4'(rm); dec_uses_rm = 1'(um);
        dec_rs      = 4'(rs); dec_uses_rs = 1'(us);
        dec_rd      = 4'(rd); dec_wr_rd   = 1'(wr);
        dec_is_load = 1'(ld); flush       = 1'(fl);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic tick();
        model_expect();
        @(posedge clk);
        if (e_stall) begin
            stalls_seen++;
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end
        cyc++;
        if (dec_valid && !e_stall && !flush)
            q.push_back('{int'(dec_rd), dec_wr_rd, dec_is_load, cyc});
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].enter < cyc - 1) q.delete(i);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("nop");
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; exp_cnt = 0; stalls_seen = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("reset");
        chk("reset.shift_lit", 32'(sel_shift_in), 32'h3);
        rst = 1'b0;
        tick();

        // ADD r1,r2,r3 then ADD r2,r1,r3
        drive(1, 2, 1, 3, 1, 0, 0, 1, 1, 0, 0); step("add1"); tick();
        drive(1, 1, 1, 3, 1, 0, 0, 2, 1, 0, 0); step("add2");
        chk("fwd.selA", 32'(sel_A_in), 32'h1);
        chk("fwd.stall", 32'(stall), 32'h0);
        chk("fwd.wen", 32'(w_en1), 32'h1);
        chk("fwd.waddr", 32'(w_addr1), 32'h1);
        tick();
        nop(); nop();

        // LDR r4,[r8] then ADD r5,r4,r6
        drive(1, 8, 1, 0, 0, 0, 0, 4, 1, 1, 0); step("ldr"); tick();
        drive(1, 4, 1, 6, 1, 0, 0, 5, 1, 0, 0); step("lu1");
        chk("lu1.stall", 32'(stall), 32'h1);
        tick();
        step("lu2");
        chk("lu2.stall", 32'(stall), 32'h1);
        chk("lu2.wsel", 32'(sel_w_data), 32'h1);
        chk("lu2.waddr", 32'(w_addr1), 32'h4);
        tick();
        step("lu3");
        chk("lu3.stall", 32'(stall), 32'h0);
        chk("lu3.selA", 32'(sel_A_in), 32'h0);
        chk("lu3.cnt", 32'(stall_cnt), 32'h2);
        tick();
        nop(); nop();

        // LDR r4 then MOV r7,#1: structural stall
        drive(1, 8, 1, 0, 0, 0, 0, 4, 1, 1, 0); step("ldr2"); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0); step("mov1");
        chk("struct.stall", 32'(stall), 32'h1);
        tick();
        step("mov2");
        chk("struct.release", 32'(stall), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("mov3");
        chk("struct.waddr", 32'(w_addr1), 32'h7);
        chk("struct.wsel", 32'(sel_w_data), 32'h0);
        tick();
        nop();

        // EX writes r15; decode reads r15 and shifts by immediate
        drive(1, 2, 1, 3, 1, 0, 0, 15, 1, 0, 0); step("wpc"); tick();
        drive(1, 15, 1, 2, 1, 0, 0, 6, 1, 0, 0); step("rpc");
        chk("pc.selA", 32'(sel_A_in), 32'h3);
        chk("pc.shift", 32'(sel_shift_in), 32'h3);
        tick();
        nop();

        // flush during a load-use stall
        drive(1, 8, 1, 0, 0, 0, 0, 4, 1, 1, 0); step("ldr3"); tick();
        drive(1, 4, 1, 6, 1, 0, 0, 5, 1, 0, 1); step("flush");
        chk("flush.stall", 32'(stall), 32'h0);
        tick();
        nop(); nop();

        // async reset in the middle of a load-use stall
        drive(1, 8, 1, 0, 0, 0, 0, 4, 1, 1, 0); step("ldr4"); tick();
        drive(1, 4, 1, 6, 1, 0, 0, 5, 1, 0, 0); step("prerst");
        chk("prerst.stall", 32'(stall), 32'h1);
        rst = 1'b1;
        #1;
        q.delete(); exp_cnt = 0;
        check_model("midrst");
        chk("midrst.stall", 32'(stall), 32'h0);
        chk("midrst.wen", 32'(w_en1), 32'h0);
        dec_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // randomized traffic over a small register set plus PC
        for (int n = 0; n < 400; n++) begin
            int r[4];
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 9) == 0) ? PC : int'($urandom_range(0, 7));
            drive(($urandom_range(0, 5) != 0), r[0], $urandom_range(0, 1), r[1], $urandom_range(0, 1),
                  r[2], $urandom_range(0, 1), r[3], $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            step("rand");
            tick();
        end

        // drive the counter past saturation
        stalls_seen = 0;
        for (int k = 0; k < 400 && stalls_seen < CNT_MAX + 5; k++) begin
            drive(1, 8, 1, 0, 0, 0, 0, 4, 1, 1, 0); step("sat.ldr"); tick();
            for (int j = 0; j < 3; j++) begin
                drive(1, 4, 1, 6, 1, 0, 0, 5, 1, 0, 0); step("sat.add"); tick();
            end
        end
        nop();
        chk("sat.cnt", 32'(stall_cnt), 32'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
